// File: rtl/pipelined_mult_stream.sv
// Streaming valid/ready multiplier: input register, multiply, PIPE_STAGES registers, output register.
// Define PIPELINED_MULT_STREAM_ACC_EN to turn the output register into a product accumulator.
module pipelined_mult_stream #(
  parameter int A_WIDTH     = 18,
  parameter int B_WIDTH     = 18,
  parameter int PIPE_STAGES = 3,
  parameter int SIGNED      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
`ifdef PIPELINED_MULT_STREAM_ACC_EN
  input  logic                       acc_first,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] mult
);

  localparam int P = A_WIDTH + B_WIDTH;

  // Handshake: a beat moves on a cycle where valid && ready are both high; ready never
  // depends on valid of the same port, and the whole pipe advances or holds as one.
  logic adv;

  logic [A_WIDTH-1:0] a_in_q;
  logic [B_WIDTH-1:0] b_in_q;
  logic               v0_q;
  logic [P-1:0]       a_ext;
  logic [P-1:0]       b_ext;
  logic [P-1:0]       prod;

  logic [P-1:0]           pipe_data_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pipe_v_q;

  logic [P-1:0] mult_q;
  logic [P-1:0] mult_d;
  logic         out_valid_q;
  logic         out_valid_d;

`ifdef PIPELINED_MULT_STREAM_ACC_EN
  logic                   f0_q;
  logic [PIPE_STAGES-1:0] pipe_f_q;
`endif

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign mult      = mult_q;

  // Extending both operands to P bits makes the P-bit product exact in either mode.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{B_WIDTH{a_in_q[A_WIDTH-1]}}, a_in_q};
      b_ext = {{A_WIDTH{b_in_q[B_WIDTH-1]}}, b_in_q};
    end else begin
      a_ext = {{B_WIDTH{1'b0}}, a_in_q};
      b_ext = {{A_WIDTH{1'b0}}, b_in_q};
    end
    prod = a_ext * b_ext;
  end

  always_comb begin
    mult_d      = mult_q;
    out_valid_d = pipe_v_q[PIPE_STAGES-1];
    if (pipe_v_q[PIPE_STAGES-1]) begin
`ifdef PIPELINED_MULT_STREAM_ACC_EN
      mult_d = (pipe_f_q[PIPE_STAGES-1] ? '0 : mult_q) + pipe_data_q[PIPE_STAGES-1];
`else
      mult_d = pipe_data_q[PIPE_STAGES-1];
`endif
    end
  end

  // Valid bits and the output register are reset; bubbles enter via v0_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      pipe_v_q    <= '0;
      out_valid_q <= 1'b0;
      mult_q      <= '0;
    end else if (adv) begin
      v0_q        <= in_valid;
      pipe_v_q[0] <= v0_q;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
      end
      out_valid_q <= out_valid_d;
      mult_q      <= mult_d;
    end
  end

  // Data payload carries no reset; its qualifying valid bit decides whether it is used.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_in_q         <= a;
      b_in_q         <= b;
      pipe_data_q[0] <= prod;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
`ifdef PIPELINED_MULT_STREAM_ACC_EN
      f0_q        <= acc_first;
      pipe_f_q[0] <= f0_q;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pipe_f_q[i] <= pipe_f_q[i-1];
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_mult_stream.sv
// Bench for pipelined_mult_stream: default unsigned instance plus a small signed instance.
// Accumulator checks run only when PIPELINED_MULT_STREAM_ACC_EN is defined.
module tb_pipelined_mult_stream;

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [35:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [17:0] a, b;
  logic [35:0] mult;
  logic        acc_first;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_a, s_b;
  logic [15:0] s_mult;
  logic        s_first;

  pipelined_mult_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef PIPELINED_MULT_STREAM_ACC_EN
    .acc_first (acc_first),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mult      (mult)
  );

  pipelined_mult_stream #(
    .A_WIDTH(8), .B_WIDTH(8), .PIPE_STAGES(3), .SIGNED(1)
  ) s_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .a         (s_a),
    .b         (s_b),
`ifdef PIPELINED_MULT_STREAM_ACC_EN
    .acc_first (s_first),
`endif
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .mult      (s_mult)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [35:0] exp_q[$];
  logic [35:0] drv_exp;
  int          n_deliv = 0;
  int          run_len = 0;
  int          max_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      run_len = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_deliv++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%0h, expected no result", mult);
        end else begin
          chk("result", {28'd0, mult}, {28'd0, exp_q.pop_front()});
        end
      end else begin
        run_len = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the beat.
  task automatic send(input logic [17:0] va, input logic [17:0] vb,
                      input logic [35:0] ve, input logic vf);
    int t;
    a         = va;
    b         = vb;
    drv_exp   = ve;
    acc_first = vf;
    in_valid  = 1'b1;
    t         = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Lone beat on an empty pipe: out_valid must pulse exactly at cycle 5.
  task automatic single_beat(input logic [17:0] va, input logic [17:0] vb, input logic [35:0] ve);
    a         = va;
    b         = vb;
    drv_exp   = ve;
    acc_first = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("latency_valid_c%0d", k), {63'd0, out_valid}, {63'd0, (k == 5)});
      if (k == 0) chk("latency_in_ready", {63'd0, in_ready}, 64'd1);
      if (k == 5) chk("latency_mult", {28'd0, mult}, {28'd0, ve});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t        vecs[7];
  logic [7:0]  sa[3];
  logic [7:0]  sb[3];
  logic [15:0] se[3];
  logic [35:0] hold;
  int          base;

  initial begin
    vecs[0] = '{18'd3,       18'd5,       36'd15};
    vecs[1] = '{18'd0,       18'h3FFFF,   36'd0};
    vecs[2] = '{18'd1,       18'h3FFFF,   36'h3FFFF};
    vecs[3] = '{18'h3FFFF,   18'h3FFFF,   36'hFFFF80001};
    vecs[4] = '{18'h20000,   18'd2,       36'h40000};
    vecs[5] = '{18'd1000,    18'd1000,    36'd1000000};
    vecs[6] = '{18'h12345,   18'h10,      36'h123450};
    sa[0] = 8'hFD; sb[0] = 8'h07; se[0] = 16'hFFEB;
    sa[1] = 8'h80; sb[1] = 8'h80; se[1] = 16'h4000;
    sa[2] = 8'h7F; sb[2] = 8'h80; se[2] = 16'hC080;

    rst = 1'b1; in_valid = 1'b1; a = 18'd9; b = 18'd9; drv_exp = '0; acc_first = 1'b1;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b1; s_first = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_mult", {28'd0, mult}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    cycles(8);
    chk("reset_no_capture", n_deliv, 0);

    // Single beat latency
    single_beat(18'd3, 18'd5, 36'd15);

    // Max-value streaming, throughput 1
    max_run = 0;
    for (int i = 0; i < 10; i++) send(18'h3FFFF, 18'h3FFFF, 36'hFFFF80001, 1'b1);
    idle();
    cycles(8);
    chk("throughput_run", max_run, 10);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) send(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
    idle();
    cycles(8);
    chk("table_drained", exp_q.size(), 0);

    // Backpressure mid-stream
    base = n_deliv;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(18'(i), 18'd2, 36'(2 * i), 1'b1);
        idle();
      end
      begin
        cycles(7);
        out_ready = 1'b0;
        @(negedge clk);
        hold = mult;
        chk("stall_first_mult", {28'd0, mult}, 64'd6);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) begin
          @(negedge clk);
          chk("stall_mult_stable", {28'd0, mult}, {28'd0, hold});
          chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
          chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    cycles(12);
    chk("bp_delivered", n_deliv - base, 8);
    chk("bp_drained", exp_q.size(), 0);

    // Reset mid-flight
    send(18'd1, 18'd1, 36'd1, 1'b1);
    send(18'd2, 18'd2, 36'd4, 1'b1);
    send(18'd3, 18'd3, 36'd9, 1'b1);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_mult", {28'd0, mult}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    base = n_deliv;
    @(posedge clk);
    #1;
    cycles(8);
    chk("midrst_no_stale", n_deliv - base, 0);
    single_beat(18'd6, 18'd7, 36'd42);

    // Signed 8x8 instance
    s_a = sa[0]; s_b = sb[0]; s_in_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("signed_valid_c%0d", k), {63'd0, s_out_valid}, {63'd0, (k >= 5 && k <= 7)});
      if (k >= 5 && k <= 7) chk($sformatf("signed_mult_%0d", k - 5), {48'd0, s_mult}, {48'd0, se[k-5]});
      @(posedge clk);
      #1;
      if (k + 1 < 3) begin
        s_a = sa[k+1];
        s_b = sb[k+1];
      end else begin
        s_in_valid = 1'b0;
      end
    end

`ifdef PIPELINED_MULT_STREAM_ACC_EN
    // Accumulation chain with restart
    send(18'd2, 18'd3, 36'd6,  1'b1);
    send(18'd4, 18'd5, 36'd26, 1'b0);
    send(18'd1, 18'd1, 36'd27, 1'b0);
    send(18'd7, 18'd1, 36'd7,  1'b1);
    idle();
    cycles(10);
    chk("acc_drained", exp_q.size(), 0);
`endif

    cycles(4);
    chk("final_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
